// File: rtl/uart_apb4_regmap.sv
// APB4 register map for a UART: control, interrupt mask/status, FIFO push/pop windows
// and read-only status words, behind a wait-state access FSM that commits each transfer once.
module uart_apb4_regmap #(
    parameter int unsigned APB_ADDR_WIDTH  = 32,
    parameter int unsigned APB_DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DATA_WIDTH = 8,
    parameter int unsigned FIFO_USED_WIDTH = 5,
    parameter int unsigned IRQ_EVENTS_NUM  = 8,
    parameter int unsigned WAIT_STATES     = 0,
    parameter logic [7:0]  IP_VERSION      = 8'h20
) (
    input  logic                       i_apb_pclk,
    input  logic                       i_apb_presetn,
    input  logic [APB_ADDR_WIDTH-1:0]  i_apb_paddr,
    input  logic [APB_DATA_WIDTH-1:0]  i_apb_pwdata,
    input  logic [3:0]                 i_apb_pstrb,
    input  logic                       i_apb_pwrite,
    input  logic                       i_apb_psel,
    input  logic                       i_apb_penable,
    output logic [APB_DATA_WIDTH-1:0]  o_apb_prdata,
    output logic                       o_apb_pready,
    output logic                       o_apb_pslverr,
    input  logic [FIFO_DATA_WIDTH-1:0] i_ufifo_rdata,
    input  logic                       i_ufifo_empty,
    input  logic                       i_dfifo_full,
    input  logic [FIFO_USED_WIDTH-1:0] i_ufifo_used,
    input  logic [FIFO_USED_WIDTH-1:0] i_dfifo_used,
    input  logic [IRQ_EVENTS_NUM-1:0]  i_irq_events,
    output logic                       o_ufifo_pop,
    output logic                       o_dfifo_push,
    output logic [FIFO_DATA_WIDTH-1:0] o_dfifo_wdata,
    output logic [31:0]                o_ctrl,
    output logic                       o_irq
);

    localparam logic [4:0] OffCtrl   = 5'h00;
    localparam logic [4:0] OffMask   = 5'h04;
    localparam logic [4:0] OffStatus = 5'h08;
    localparam logic [4:0] OffDfifo  = 5'h0C;
    localparam logic [4:0] OffUfifo  = 5'h10;
    localparam logic [4:0] OffStats  = 5'h14;
    localparam logic [4:0] OffHwinfo = 5'h18;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                      state_q, state_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic                        commit;

    logic [31:0]                 ctrl_q, ctrl_d;
    logic [IRQ_EVENTS_NUM-1:0]   mask_q, mask_d;
    logic [IRQ_EVENTS_NUM-1:0]   status_q, status_d;
    logic [IRQ_EVENTS_NUM-1:0]   clr;
    logic                        irq_q;

    logic [APB_DATA_WIDTH-1:0]   prdata_q;
    logic                        pslverr_q;
    logic                        pop_q;
    logic                        push_q;
    logic [FIFO_DATA_WIDTH-1:0]  wdata_q;

    logic [4:0]                  reg_off;
    logic [31:0]                 wmask;
    logic [31:0]                 rd_data;
    logic                        acc_err;
    logic                        ctrl_wr;
    logic                        mask_wr;
    logic                        stat_wr;
    logic                        push_req;
    logic                        pop_req;
    logic                        ok;
    logic                        unused_paddr;

    assign reg_off      = i_apb_paddr[4:0];
    assign unused_paddr = ^i_apb_paddr;

    // FSM: state register
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; dropping psel in the wait phase abandons the transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (i_apb_psel && i_apb_penable) state_d = StWait;
            StWait: begin
                if (!i_apb_psel) begin
                    state_d = StIdle;
                end else if (cnt_q == 3'd0) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_apb_pready = (state_q == StResp);
        commit       = (state_q == StWait) && i_apb_psel && (cnt_q == 3'd0);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle && i_apb_psel && i_apb_penable) begin
            cnt_d = 3'(WAIT_STATES);
        end else if (state_q == StWait && cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{i_apb_pstrb[i]}};
        end
    end

    // Address decode and access legality for the transfer currently on the bus
    always_comb begin
        rd_data  = '0;
        acc_err  = (i_apb_paddr[1:0] != 2'b00);
        ctrl_wr  = 1'b0;
        mask_wr  = 1'b0;
        stat_wr  = 1'b0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        case (reg_off)
            OffCtrl: begin
                if (i_apb_pwrite) ctrl_wr = 1'b1;
                else              rd_data = ctrl_q;
            end
            OffMask: begin
                if (i_apb_pwrite) mask_wr = 1'b1;
                else              rd_data = 32'(mask_q);
            end
            OffStatus: begin
                if (i_apb_pwrite) stat_wr = 1'b1;
                else              rd_data = 32'(status_q);
            end
            OffDfifo: begin
                if (!i_apb_pwrite || i_dfifo_full) acc_err  = 1'b1;
                else                               push_req = i_apb_pstrb[0];
            end
            OffUfifo: begin
                if (i_apb_pwrite || i_ufifo_empty) begin
                    acc_err = 1'b1;
                end else begin
                    pop_req = 1'b1;
                    rd_data = 32'(i_ufifo_rdata);
                end
            end
            OffStats: begin
                if (i_apb_pwrite) acc_err = 1'b1;
                else rd_data = {8'h00, 8'(i_dfifo_used), 8'(i_ufifo_used), 6'h00,
                                i_dfifo_full, i_ufifo_empty};
            end
            OffHwinfo: begin
                if (i_apb_pwrite) acc_err = 1'b1;
                else rd_data = {5'h00, 3'(WAIT_STATES), 4'h0, 4'(FIFO_DATA_WIDTH), 3'h0,
                                5'(IRQ_EVENTS_NUM), IP_VERSION};
            end
            default: acc_err = 1'b1;
        endcase
    end

    assign ok = commit && !acc_err;

    always_comb begin
        ctrl_d = ctrl_q;
        mask_d = mask_q;
        clr    = '0;
        if (ok && ctrl_wr) begin
            ctrl_d = (ctrl_q & ~wmask) | (i_apb_pwdata[31:0] & wmask);
        end
        if (ok && mask_wr) begin
            mask_d = (mask_q & ~wmask[IRQ_EVENTS_NUM-1:0])
                   | (i_apb_pwdata[IRQ_EVENTS_NUM-1:0] & wmask[IRQ_EVENTS_NUM-1:0]);
        end
        if (ok && stat_wr) begin
            clr = i_apb_pwdata[IRQ_EVENTS_NUM-1:0] & wmask[IRQ_EVENTS_NUM-1:0];
        end
        // New events are OR-ed in after the clear so a coincident set survives
        status_d = (status_q & ~clr) | i_irq_events;
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            ctrl_q   <= '0;
            mask_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            irq_q    <= |(status_q & mask_q);
        end
    end

    // Response and FIFO strobes are captured at the commit edge and thus line up with RESP
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            pop_q     <= 1'b0;
            push_q    <= 1'b0;
            wdata_q   <= '0;
        end else begin
            pop_q  <= ok && pop_req;
            push_q <= ok && push_req;
            if (commit) begin
                prdata_q  <= acc_err ? '0 : APB_DATA_WIDTH'(rd_data);
                pslverr_q <= acc_err;
            end
            if (ok && push_req) begin
                wdata_q <= i_apb_pwdata[FIFO_DATA_WIDTH-1:0];
            end
        end
    end

    assign o_apb_prdata  = prdata_q;
    assign o_apb_pslverr = pslverr_q;
    assign o_ufifo_pop   = pop_q;
    assign o_dfifo_push  = push_q;
    assign o_dfifo_wdata = wdata_q;
    assign o_ctrl        = ctrl_q;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_uart_apb4_regmap.sv
// Directed bench for uart_apb4_regmap with two wait states: register access, FIFO windows,
// sticky interrupts, error responses, aborted transfers and reset mid-transfer.
module tb_uart_apb4_regmap;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  ufifo_rdata = '0;
    logic        ufifo_empty = 1'b1;
    logic        dfifo_full = 1'b0;
    logic [4:0]  ufifo_used = '0;
    logic [4:0]  dfifo_used = '0;
    logic [7:0]  irq_events = '0;
    logic        ufifo_pop;
    logic        dfifo_push;
    logic [7:0]  dfifo_wdata;
    logic [31:0] ctrl;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int pop_cnt = 0;
    int push_cnt = 0;
    int rdy_cnt = 0;

    uart_apb4_regmap #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .FIFO_DATA_WIDTH(8),
        .FIFO_USED_WIDTH(5),
        .IRQ_EVENTS_NUM (8),
        .WAIT_STATES    (WS),
        .IP_VERSION     (8'h20)
    ) dut (
        .i_apb_pclk   (clk),
        .i_apb_presetn(presetn),
        .i_apb_paddr  (paddr),
        .i_apb_pwdata (pwdata),
        .i_apb_pstrb  (pstrb),
        .i_apb_pwrite (pwrite),
        .i_apb_psel   (psel),
        .i_apb_penable(penable),
        .o_apb_prdata (prdata),
        .o_apb_pready (pready),
        .o_apb_pslverr(pslverr),
        .i_ufifo_rdata(ufifo_rdata),
        .i_ufifo_empty(ufifo_empty),
        .i_dfifo_full (dfifo_full),
        .i_ufifo_used (ufifo_used),
        .i_dfifo_used (dfifo_used),
        .i_irq_events (irq_events),
        .o_ufifo_pop  (ufifo_pop),
        .o_dfifo_push (dfifo_push),
        .o_dfifo_wdata(dfifo_wdata),
        .o_ctrl       (ctrl),
        .o_irq        (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ufifo_pop)  pop_cnt++;
        if (dfifo_push) push_cnt++;
        if (pready)     rdy_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // cyc counts falling edges after penable rises; ev pulses across the commit edge;
    // cut_at>0 aborts (psel drop) or resets the block at that cycle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [7:0] ev, input int cut_at,
                        input bit cut_rst, output logic [31:0] rdata, output logic err,
                        output int cyc, output logic irq_r);
        bit done;
        @(negedge clk);
        paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        cyc = 0; rdata = '0; err = 1'b0; irq_r = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            irq_events = (cyc == WS + 1) ? ev : 8'h00;
            if (cyc == cut_at) begin
                if (cut_rst) presetn = 1'b0;
                else begin psel = 1'b0; penable = 1'b0; end
                done = 1'b1;
            end else if (pready) begin
                rdata = prdata; err = pslverr; irq_r = irq; done = 1'b1;
            end else if (cyc >= 20) begin
                done = 1'b1;
            end
        end
        irq_events = 8'h00;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        ir;
        int          cyc;
        int          p0;
        int          q0;

        repeat (3) @(negedge clk);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_pop", 32'(ufifo_pop), 32'h0);
        check("rst_push", 32'(dfifo_push), 32'h0);
        check("rst_wdata", 32'(dfifo_wdata), 32'h0);
        check("rst_ctrl", ctrl, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        presetn = 1'b1;

        // Bytes 0 and 2 only; RESP is the 4th cycle after the sampling edge
        xfer(1, 32'h00, 32'hA5A5_A5A5, 4'b0101, 8'h00, 0, 0, rd, er, cyc, ir);
        check("ctrl_wr_cycles", 32'(cyc), 32'd4);
        check("ctrl_wr_err", 32'(er), 32'h0);
        check("ctrl_out", ctrl, 32'h00A5_00A5);
        xfer(0, 32'h00, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("ctrl_rd", rd, 32'h00A5_00A5);

        xfer(0, 32'h18, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("hwinfo", rd, 32'h0208_0820);
        ufifo_used = 5'd3; dfifo_used = 5'd17; dfifo_full = 1'b0; ufifo_empty = 1'b1;
        xfer(0, 32'h14, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("stats", rd, 32'h0011_0301);

        p0 = push_cnt;
        xfer(1, 32'h0C, 32'h0000_01C3, 4'hF, 8'h00, 0, 0, rd, er, cyc, ir);
        check("dfifo_err", 32'(er), 32'h0);
        check("dfifo_pushes", 32'(push_cnt - p0), 32'd1);
        check("dfifo_wdata", 32'(dfifo_wdata), 32'h0000_00C3);
        dfifo_full = 1'b1;
        p0 = push_cnt;
        xfer(1, 32'h0C, 32'h0000_0055, 4'hF, 8'h00, 0, 0, rd, er, cyc, ir);
        check("dfifo_full_err", 32'(er), 32'h1);
        check("dfifo_full_pushes", 32'(push_cnt - p0), 32'd0);
        check("dfifo_full_wdata", 32'(dfifo_wdata), 32'h0000_00C3);
        dfifo_full = 1'b0;
        p0 = push_cnt;
        xfer(1, 32'h0C, 32'h0000_0077, 4'b1110, 8'h00, 0, 0, rd, er, cyc, ir);
        check("dfifo_nostrb_err", 32'(er), 32'h0);
        check("dfifo_nostrb_pushes", 32'(push_cnt - p0), 32'd0);

        ufifo_rdata = 8'h5A; ufifo_empty = 1'b0;
        p0 = pop_cnt;
        xfer(0, 32'h10, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("ufifo_rd", rd, 32'h0000_005A);
        check("ufifo_err", 32'(er), 32'h0);
        check("ufifo_pops", 32'(pop_cnt - p0), 32'd1);
        ufifo_empty = 1'b1;
        p0 = pop_cnt;
        xfer(0, 32'h10, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("ufifo_empty_rd", rd, 32'h0);
        check("ufifo_empty_err", 32'(er), 32'h1);
        check("ufifo_empty_pops", 32'(pop_cnt - p0), 32'd0);

        xfer(1, 32'h04, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 0, rd, er, cyc, ir);
        xfer(0, 32'h04, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("mask_upper_zero", rd, 32'h0000_00FF);
        xfer(1, 32'h04, 32'h0000_0008, 4'b0001, 8'h00, 0, 0, rd, er, cyc, ir);
        xfer(0, 32'h04, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("mask_rd", rd, 32'h0000_0008);

        // Unmasked event source: sticky status, no interrupt
        @(negedge clk); irq_events = 8'h02;
        @(negedge clk); irq_events = 8'h00;
        repeat (2) @(negedge clk);
        check("irq_masked_off", 32'(irq), 32'h0);

        xfer(1, 32'h08, 32'h0000_0008, 4'hF, 8'h08, 0, 0, rd, er, cyc, ir);
        check("irq_set_resp", 32'(ir), 32'h0);
        check("irq_set_after", 32'(irq), 32'h1);
        xfer(0, 32'h08, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("status_set_wins", rd, 32'h0000_000A);
        xfer(1, 32'h08, 32'h0000_000A, 4'b0001, 8'h00, 0, 0, rd, er, cyc, ir);
        check("irq_clr_resp", 32'(ir), 32'h1);
        check("irq_clr_after", 32'(irq), 32'h0);
        xfer(0, 32'h08, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("status_cleared", rd, 32'h0);

        xfer(1, 32'h01, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 0, rd, er, cyc, ir);
        check("misalign_wr_err", 32'(er), 32'h1);
        check("misalign_ctrl", ctrl, 32'h00A5_00A5);
        xfer(0, 32'h02, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("misalign_rd_err", 32'(er), 32'h1);
        check("misalign_rd_data", rd, 32'h0);
        xfer(1, 32'h1C, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 0, rd, er, cyc, ir);
        check("unmapped_err", 32'(er), 32'h1);
        xfer(1, 32'h14, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 0, rd, er, cyc, ir);
        check("wr_stats_err", 32'(er), 32'h1);
        xfer(0, 32'h0C, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("rd_dfifo_err", 32'(er), 32'h1);
        check("rd_dfifo_data", rd, 32'h0);
        xfer(0, 32'h00, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("err_ctrl_kept", rd, 32'h00A5_00A5);

        q0 = rdy_cnt;
        xfer(1, 32'h00, 32'hFFFF_FFFF, 4'hF, 8'h00, 1, 0, rd, er, cyc, ir);
        repeat (4) @(negedge clk);
        check("abort_no_ready", 32'(rdy_cnt - q0), 32'd0);
        check("abort_ctrl", ctrl, 32'h00A5_00A5);
        xfer(0, 32'h00, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("post_abort_cycles", 32'(cyc), 32'd4);
        check("post_abort_rd", rd, 32'h00A5_00A5);

        ufifo_empty = 1'b0;
        p0 = pop_cnt;
        xfer(0, 32'h10, 32'h0, 4'h0, 8'h00, 2, 1, rd, er, cyc, ir);
        repeat (2) @(negedge clk);
        check("rst_wait_pops", 32'(pop_cnt - p0), 32'd0);
        check("rst_wait_prdata", prdata, 32'h0);
        check("rst_wait_ctrl", ctrl, 32'h0);
        check("rst_wait_wdata", 32'(dfifo_wdata), 32'h0);
        check("rst_wait_ready", 32'(pready), 32'h0);
        presetn = 1'b1;
        p0 = pop_cnt;
        xfer(0, 32'h10, 32'h0, 4'h0, 8'h00, 0, 0, rd, er, cyc, ir);
        check("post_rst_cycles", 32'(cyc), 32'd4);
        check("post_rst_rd", rd, 32'h0000_005A);
        check("post_rst_pops", 32'(pop_cnt - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_apb4_regmap.md
UART_APB4_REGMAP -- requirements
Module: uart_apb4_regmap

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- APB_ADDR_WIDTH, 32, PADDR width; only bits [4:0] decoded.
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32.
- FIFO_DATA_WIDTH, 8, UFIFO/DFIFO data width, 5..9.
- FIFO_USED_WIDTH, 5, width of FIFO used-count inputs, 1..8.
- IRQ_EVENTS_NUM, 8, number of interrupt event sources, 1..16.
- WAIT_STATES, 0, extra access-phase cycles before PREADY, 0..7.
- IP_VERSION, 8'h20, value reported in HWINFO[7:0].
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_apb_pclk, in, 1, the single clock.
- i_apb_presetn, in, 1, asynchronous active-low reset.
- i_apb_paddr, in, APB_ADDR_WIDTH, address.
- i_apb_pwdata, in, 32, write data.
- i_apb_pstrb, in, 4, byte write strobes.
- i_apb_pwrite / i_apb_psel / i_apb_penable, in, 1 each, APB4 controls.
- o_apb_prdata, out, 32, read data.
- o_apb_pready / o_apb_pslverr, out, 1 each, transfer completion and error.
- i_ufifo_rdata, in, FIFO_DATA_WIDTH, show-ahead UFIFO head.
- i_ufifo_empty / i_dfifo_full, in, 1 each, FIFO flags.
- i_ufifo_used / i_dfifo_used, in, FIFO_USED_WIDTH each, fill levels.
- i_irq_events, in, IRQ_EVENTS_NUM, one-cycle event pulses.
- o_ufifo_pop / o_dfifo_push, out, 1 each, single-cycle FIFO strobes.
- o_dfifo_wdata, out, FIFO_DATA_WIDTH, push data.
- o_ctrl, out, 32, CTRL register contents.
- o_irq, out, 1, level interrupt.

Function
REQ-003 The map SHALL be: 0x00 CTRL RW; 0x04 IRQ_MASK RW; 0x08 IRQ_STATUS W1C; 0x0C DFIFO WO (write pushes); 0x10 UFIFO RO (read pops); 0x14 STATS RO = {dfifo_used@[23:16], ufifo_used@[15:8], dfifo_full@1, ufifo_empty@0}; 0x18 HWINFO RO = {WAIT_STATES@[26:24], FIFO_DATA_WIDTH@[19:16], IRQ_EVENTS_NUM@[12:8], IP_VERSION@[7:0]}.
REQ-004 The FSM SHALL have states IDLE, WAIT, RESP: IDLE->WAIT when psel&&penable at the clock edge, loading counter = WAIT_STATES.
REQ-005 In WAIT, counter==0 SHALL go to RESP (the commit edge); otherwise counter decrements.
REQ-006 RESP SHALL last exactly one cycle with o_apb_pready=1, then return to IDLE; total access-phase length = WAIT_STATES+2 cycles.
REQ-007 psel deasserted in WAIT SHALL abort to IDLE with no side effects.
REQ-008 All side effects SHALL occur once, at the commit edge; o_apb_prdata and o_apb_pslverr SHALL be registered there and held through RESP.
REQ-009 pslverr SHALL be set for: paddr[1:0]!=0; offsets >0x18; writes to 0x10/0x14/0x18; reads of 0x0C; DFIFO write with i_dfifo_full=1; UFIFO read with i_ufifo_empty=1.
REQ-010 An errored transfer SHALL have no side effects and prdata=0.
REQ-011 CTRL and IRQ_MASK writes SHALL update only bytes with pstrb set; IRQ_MASK bits >= IRQ_EVENTS_NUM SHALL read 0.
REQ-012 A DFIFO write SHALL require pstrb[0]=1; o_dfifo_wdata = pwdata[FIFO_DATA_WIDTH-1:0], held until the next push; o_dfifo_push=1 during RESP.
- A DFIFO write with pstrb[0]=0 SHALL complete OKAY with no push.
REQ-013 A UFIFO read SHALL return zero-extended i_ufifo_rdata; o_ufifo_pop=1 during RESP.
REQ-014 IRQ_STATUS SHALL be sticky: next = (status & ~clr) | i_irq_events, with clr = pwdata masked by pstrb on a committed write; a simultaneous set SHALL win over clear.
REQ-015 o_irq SHALL be registered |(IRQ_STATUS & IRQ_MASK), one cycle after the status change.
REQ-016 pready SHALL never be asserted outside RESP.

Reset
REQ-017 Reset SHALL be asynchronous: FSM=IDLE, counter=0; CTRL, IRQ_MASK, IRQ_STATUS, o_apb_prdata, o_dfifo_wdata all 0; o_apb_pready, o_apb_pslverr, o_ufifo_pop, o_dfifo_push, o_irq all 0.
REQ-018 Reset during WAIT or RESP SHALL drop the transfer with no push or pop.

Verification
REQ-019 WAIT_STATES=2, write CTRL=0xA5A5A5A5 with pstrb=4'b0101 -> pready high in the 4th access cycle; CTRL reads 0x00A500A5.
REQ-020 DFIFO write 0x1C3 with full=0 -> one o_dfifo_push, wdata=0xC3; repeated with full=1 -> pslverr=1, no push.
REQ-021 UFIFO read with rdata=0x5A, empty=0 -> prdata=0x5A, one pop; with empty=1 -> pslverr=1, prdata=0, no pop.
REQ-022 Event[3] pulsed on the same edge as a W1C of 0x08 -> status[3] stays 1; with mask=0x08, o_irq=1; a later W1C clears status and o_irq next cycle.
REQ-023 Misaligned 0x02, unmapped 0x1C, write to 0x14 -> pslverr=1 each, no state change.
REQ-024 Reset asserted during WAIT of a UFIFO read -> no pop; all outputs 0; next transfer completes normally.
